// File: rtl/parallel_to_serial.sv
// LSB-first serializer with a valid/ready word input, a valid/ready bit output and a
// one-word holding buffer so consecutive words stream without an idle cycle.
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    input  logic [width-1:0] parallel_data,
    output logic             parallel_ready,
    output logic             serial_valid,
    output logic             serial_data,
    input  logic             serial_ready,
    output logic             busy
);

    localparam int cw = $clog2(width);
    localparam logic [cw-1:0] last_bit = cw'(width - 1);

    logic [width-1:0] shifter_reg, shifter_next;
    logic [cw-1:0]    count_reg, count_next;
    logic             active_reg, active_next;
    logic [width-1:0] buffer_reg, buffer_next;
    logic             buffer_full_reg, buffer_full_next;

    logic accept;
    logic advance;
    logic done;

    // State register: reset takes effect immediately, release is sampled by clk.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shifter_reg     <= '0;
            count_reg       <= '0;
            active_reg      <= 1'b0;
            buffer_reg      <= '0;
            buffer_full_reg <= 1'b0;
        end else begin
            shifter_reg     <= shifter_next;
            count_reg       <= count_next;
            active_reg      <= active_next;
            buffer_reg      <= buffer_next;
            buffer_full_reg <= buffer_full_next;
        end
    end

    assign accept  = parallel_valid && !buffer_full_reg;
    assign advance = active_reg && serial_ready;
    assign done    = advance && (count_reg == last_bit);

    // Next-state logic.
    always_comb begin
        shifter_next     = shifter_reg;
        count_next       = count_reg;
        active_next      = active_reg;
        buffer_next      = buffer_reg;
        buffer_full_next = buffer_full_reg;

        if (!active_reg || done) begin
            if (buffer_full_reg) begin
                // accept cannot occur here, so the buffer simply drains into the shifter
                shifter_next     = buffer_reg;
                count_next       = '0;
                active_next      = 1'b1;
                buffer_full_next = 1'b0;
            end else if (accept) begin
                shifter_next = parallel_data;
                count_next   = '0;
                active_next  = 1'b1;
            end else begin
                active_next = 1'b0;
            end
        end else begin
            if (advance) begin
                shifter_next = {1'b0, shifter_reg[width-1:1]};
                count_next   = count_reg + 1'b1;
            end
            if (accept) begin
                buffer_next      = parallel_data;
                buffer_full_next = 1'b1;
            end
        end
    end

    // Outputs depend on registered state only.
    always_comb begin
        parallel_ready = !buffer_full_reg;
        serial_valid   = active_reg;
        serial_data    = shifter_reg[0];
        busy           = active_reg || buffer_full_reg;
    end

endmodule
